multi_sensor_fsm: RTL and testbench

//  Periodic sequencer that polls NumChannels sensor channels through a shared Measure-FSM, one after another.

---
 rtl/multi_sensor_fsm_pkg.sv | 17 +
 rtl/sensor_fsm_timer.sv | 27 ++
 rtl/multi_sensor_fsm.sv | 178 +++++++++++++++++
 tb/tb_multi_sensor_fsm.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_sensor_fsm_pkg.sv
// Shared state encoding and channel-index width helper for the multi-sensor sequencer.
package multi_sensor_fsm_pkg;

   typedef enum logic [2:0] {
      stDisabled = 3'd0,
      stIdle     = 3'd1,
      stWait     = 3'd2,
      stGap      = 3'd3,
      stNotify   = 3'd4,
      stError    = 3'd5
   } state_t;

   function automatic int chWidth(input int numCh);
      return (numCh > 1) ? $clog2(numCh) : 1;
   endfunction

endpackage

// File: rtl/sensor_fsm_timer.sv
// Poll-period down-counter: loads a preset, counts down to zero and holds there.
module sensor_fsm_timer #(
   parameter int Width = 32
) (
   input  logic             Clk_i,
   input  logic             Reset_n_i,
   input  logic             Preset_i,
   input  logic             Enable_i,
   input  logic [Width-1:0] PresetVal_i,
   output logic             Ovfl_o
);

   logic [Width-1:0] count;

   always_ff @(posedge Clk_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         count <= '0;
      end else if (Preset_i) begin
         count <= PresetVal_i;
      end else if (Enable_i && (count != '0)) begin
         count <= count - Width'(1);
      end
   end

   assign Ovfl_o = (count == '0);

endmodule

// File: rtl/multi_sensor_fsm.sv
// Periodic sequencer polling NumChannels sensors through a shared Measure-FSM.
// Optional build macro SENSOR_FSM_DELTA_EN: round interrupts only when a channel moved beyond ParamThreshold_i.
module multi_sensor_fsm
   import multi_sensor_fsm_pkg::*;
#(
   parameter  int DataWidth   = 8,
   parameter  int NumChannels = 2,
   localparam int ChW         = chWidth(NumChannels),
   localparam int WordW       = 2 * DataWidth
) (
   input  logic                         Clk_i,
   input  logic                         Reset_n_i,
   input  logic                         Enable_i,
   output logic                         CpuIntr_o,
   output logic [NumChannels*WordW-1:0] SensorValues_o,
   output logic                         ErrorFlag_o,
   output logic [ChW-1:0]               ErrorChannel_o,
   output logic                         MeasureFSM_Query_o,
   output logic [ChW-1:0]               MeasureFSM_Channel_o,
   input  logic                         MeasureFSM_Done_i,
   input  logic                         MeasureFSM_Error_i,
   input  logic [DataWidth-1:0]         MeasureFSM_Byte0_i,
   input  logic [DataWidth-1:0]         MeasureFSM_Byte1_i,
   input  logic [WordW-1:0]             ParamCounterPresetH_i,
   input  logic [WordW-1:0]             ParamCounterPresetL_i,
   input  logic [WordW-1:0]             ParamThreshold_i
);

   localparam logic [ChW-1:0] LastCh = ChW'(NumChannels - 1);

   state_t           state, nextState;
   logic [ChW-1:0]   chIdx;
   logic [ChW-1:0]   errorCh;
   logic [WordW-1:0] words [NumChannels];
   logic [WordW-1:0] newWord;
   logic             gapQuery;
   logic             timerPreset, timerEnable, timerOvfl;
   logic             idleQuery, storeWord, latchError, advanceCh;
   logic             errIntr, notify, notifyAllowed;

   assign newWord = {MeasureFSM_Byte1_i, MeasureFSM_Byte0_i};

   sensor_fsm_timer #(
      .Width(4 * DataWidth)
   ) timer (
      .Clk_i      (Clk_i),
      .Reset_n_i  (Reset_n_i),
      .Preset_i   (timerPreset),
      .Enable_i   (timerEnable),
      .PresetVal_i({ParamCounterPresetH_i, ParamCounterPresetL_i}),
      .Ovfl_o     (timerOvfl)
   );

   always_comb begin
      nextState   = state;
      timerPreset = 1'b0;
      timerEnable = 1'b0;
      idleQuery   = 1'b0;
      storeWord   = 1'b0;
      latchError  = 1'b0;
      advanceCh   = 1'b0;
      errIntr     = 1'b0;
      notify      = 1'b0;
      case (state)
         stDisabled: begin
            if (Enable_i) begin
               timerPreset = 1'b1;
               nextState   = stIdle;
            end
         end
         stIdle: begin
            if (!Enable_i) begin
               nextState = stDisabled;
            end else if (timerOvfl) begin
               idleQuery = 1'b1;
               nextState = stWait;
            end else begin
               timerEnable = 1'b1;
            end
         end
         stWait: begin
            if (MeasureFSM_Error_i) begin
               errIntr    = 1'b1;
               latchError = 1'b1;
               nextState  = stError;
            end else if (MeasureFSM_Done_i) begin
               storeWord = 1'b1;
               if (chIdx == LastCh) begin
                  nextState = stNotify;
               end else begin
                  advanceCh = 1'b1;
                  nextState = stGap;
               end
            end
         end
         stGap:    nextState = stWait;
         stNotify: begin
            timerPreset = 1'b1;
            notify      = 1'b1;
            nextState   = stIdle;
         end
         stError: begin
            if (!Enable_i) nextState = stDisabled;
         end
         default:  nextState = stDisabled;
      endcase
   end

   // Queries for ch>0 leave stGap through a register so the Measure-FSM sees an idle cycle after Done.
   always_ff @(posedge Clk_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         state    <= stDisabled;
         chIdx    <= '0;
         errorCh  <= '0;
         gapQuery <= 1'b0;
      end else begin
         state    <= nextState;
         gapQuery <= (state == stGap);
         if (timerPreset) begin
            chIdx <= '0;
         end else if (advanceCh) begin
            chIdx <= chIdx + ChW'(1);
         end
         if (latchError) errorCh <= chIdx;
      end
   end

   always_ff @(posedge Clk_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         for (int k = 0; k < NumChannels; k++) words[k] <= '0;
      end else if (storeWord) begin
         words[chIdx] <= newWord;
      end
   end

   for (genvar k = 0; k < NumChannels; k++) begin : g_pack
      assign SensorValues_o[k*WordW +: WordW] = words[k];
   end

`ifdef SENSOR_FSM_DELTA_EN
   logic deltaHit, firstRound;

   function automatic logic [WordW-1:0] absDiff(input logic [WordW-1:0] a, input logic [WordW-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   // The stored word is still the previous sample when the new one arrives.
   always_ff @(posedge Clk_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         deltaHit   <= 1'b0;
         firstRound <= 1'b0;
      end else begin
         if ((state == stDisabled) && Enable_i) begin
            firstRound <= 1'b1;
            deltaHit   <= 1'b0;
         end else if (notify) begin
            firstRound <= 1'b0;
            deltaHit   <= 1'b0;
         end else if (storeWord && (absDiff(newWord, words[chIdx]) > ParamThreshold_i)) begin
            deltaHit <= 1'b1;
         end
      end
   end

   assign notifyAllowed = firstRound | deltaHit;
`else
   logic unusedThreshold;
   assign unusedThreshold = ^ParamThreshold_i;
   assign notifyAllowed   = 1'b1;
`endif

   assign CpuIntr_o            = errIntr | (notify & notifyAllowed);
   assign ErrorFlag_o          = (state == stError);
   assign ErrorChannel_o       = errorCh;
   assign MeasureFSM_Query_o   = idleQuery | gapQuery;
   assign MeasureFSM_Channel_o = chIdx;

endmodule

// File: tb/tb_multi_sensor_fsm.sv
// Scoreboard bench for multi_sensor_fsm (DataWidth=8, NumChannels=2); delta rounds run when SENSOR_FSM_DELTA_EN is defined.
module tb_multi_sensor_fsm;

   localparam int DW  = 8;
   localparam int NCH = 2;
   localparam int WW  = 2 * DW;

   logic              Clk_i = 1'b0;
   logic              Reset_n_i;
   logic              Enable_i;
   logic              CpuIntr_o;
   logic [NCH*WW-1:0] SensorValues_o;
   logic              ErrorFlag_o;
   logic [0:0]        ErrorChannel_o;
   logic              Query;
   logic [0:0]        Channel;
   logic              Done, Err;
   logic [DW-1:0]     Byte0, Byte1;
   logic [WW-1:0]     PresetH, PresetL, Threshold;

   int nChecks    = 0;
   int nFails     = 0;
   int queryCount = 0;
   logic [WW-1:0]     expWords [NCH];
   logic [NCH*WW-1:0] expIntrQ [$];

   always #5 Clk_i = ~Clk_i;

   multi_sensor_fsm #(.DataWidth(DW), .NumChannels(NCH)) dut (
      .Clk_i                (Clk_i),
      .Reset_n_i            (Reset_n_i),
      .Enable_i             (Enable_i),
      .CpuIntr_o            (CpuIntr_o),
      .SensorValues_o       (SensorValues_o),
      .ErrorFlag_o          (ErrorFlag_o),
      .ErrorChannel_o       (ErrorChannel_o),
      .MeasureFSM_Query_o   (Query),
      .MeasureFSM_Channel_o (Channel),
      .MeasureFSM_Done_i    (Done),
      .MeasureFSM_Error_i   (Err),
      .MeasureFSM_Byte0_i   (Byte0),
      .MeasureFSM_Byte1_i   (Byte1),
      .ParamCounterPresetH_i(PresetH),
      .ParamCounterPresetL_i(PresetL),
      .ParamThreshold_i     (Threshold)
   );

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NCH*WW-1:0] packWords();
      return {expWords[1], expWords[0]};
   endfunction

   task automatic step();
      @(negedge Clk_i);
      #1;
   endtask

   // Monitor: counts queries and pops the scoreboard on every interrupt.
   initial begin
      forever begin
         @(negedge Clk_i);
         #2;
         if (Query) queryCount++;
         if (CpuIntr_o) begin
            checkVal("intrExpected", 64'(expIntrQ.size() > 0), 1);
            if (expIntrQ.size() > 0) checkVal("intrWords", SensorValues_o, expIntrQ.pop_front());
         end
      end
   end

   task automatic waitQuery(input int budget, output int waited);
      waited = 0;
      do begin
         step();
         waited++;
      end while (!Query && (waited < budget));
      checkVal("queryArrived", Query, 1);
   endtask

   task automatic respond(input int ch, input logic [WW-1:0] w, input bit isErr,
                          input bit pushIntr, input bit dropEn);
      checkVal("queryCh", Channel, ch);
      step();
      checkVal("chHeld", Channel, ch);
      if (dropEn) Enable_i = 1'b0;
      Byte0 = w[DW-1:0];
      Byte1 = w[WW-1:DW];
      Done  = 1'b1;
      if (isErr) begin
         expIntrQ.push_back(packWords());
         Err = 1'b1;
      end else begin
         expWords[ch] = w;
         if (pushIntr) expIntrQ.push_back(packWords());
      end
      step();
      Done = 1'b0;
      Err  = 1'b0;
   endtask

   task automatic runRound(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                           input bit expIntr, input int expLat, input bit dropEn);
      int waited;
      waitQuery(40, waited);
      checkVal("firstQueryLat", waited, expLat);
      respond(0, w0, 1'b0, 1'b0, dropEn);
      waitQuery(10, waited);
      checkVal("gapQueryLat", waited + 1, 2);
      respond(1, w1, 1'b0, expIntr, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int waited;
      int q0;
      Reset_n_i = 1'b0;
      Enable_i  = 1'b0;
      Done      = 1'b0;
      Err       = 1'b0;
      Byte0     = '0;
      Byte1     = '0;
      PresetH   = 16'h0000;
      PresetL   = 16'h0003;
      Threshold = 16'h0010;
      for (int k = 0; k < NCH; k++) expWords[k] = '0;
      repeat (3) step();
      Reset_n_i = 1'b1;

      // Disabled idle: nothing moves
      repeat (20) step();
      checkVal("rstIntr", CpuIntr_o, 0);
      checkVal("rstValues", SensorValues_o, 0);
      checkVal("rstErrFlag", ErrorFlag_o, 0);
      checkVal("rstErrCh", ErrorChannel_o, 0);
      checkVal("rstQuery", Query, 0);
      checkVal("rstChannel", Channel, 0);
      checkVal("rstNoQuery", queryCount, 0);
      Done = 1'b1; Byte0 = 8'hEE; Byte1 = 8'hEE;
      step();
      Done = 1'b0;
      step();
      checkVal("doneIgnoredDisabled", SensorValues_o, 0);

      // Normal round, preset 3
      Enable_i = 1'b1;
      runRound(16'h1234, 16'hABCD, 1'b1, 4, 1'b0);
      checkVal("round1Words", SensorValues_o, 32'hABCD_1234);

      // Error on ch1 (Done raised alongside must lose)
      waitQuery(40, waited);
      checkVal("round2Lat", waited, 4);
      respond(0, 16'h5555, 1'b0, 1'b0, 1'b0);
      waitQuery(10, waited);
      respond(1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      checkVal("errFlag", ErrorFlag_o, 1);
      checkVal("errChannel", ErrorChannel_o, 1);
      checkVal("errWords", SensorValues_o, 32'hABCD_5555);
      q0 = queryCount;
      repeat (15) step();
      checkVal("noQueryInError", queryCount, q0);
      checkVal("errFlagHeld", ErrorFlag_o, 1);
      Enable_i = 1'b0;
      step();
      checkVal("errFlagCleared", ErrorFlag_o, 0);

      // Enable dropped mid-round: round still completes
      step();
      Enable_i = 1'b1;
      runRound(16'h1111, 16'h2222, 1'b1, 4, 1'b1);
      checkVal("dropEnWords", SensorValues_o, 32'h2222_1111);
      q0 = queryCount;
      repeat (10) step();
      checkVal("noQueryAfterDrop", queryCount, q0);

`ifdef SENSOR_FSM_DELTA_EN
      Enable_i = 1'b1;
      runRound(16'h0100, 16'h0200, 1'b1, 4, 1'b0);
      runRound(16'h0100, 16'h0200, 1'b0, 4, 1'b0);
      runRound(16'h0120, 16'h0200, 1'b1, 4, 1'b0);
      runRound(16'h0110, 16'h0200, 1'b0, 4, 1'b0);
      checkVal("deltaWords", SensorValues_o, 32'h0200_0110);
      Enable_i = 1'b0;
      repeat (3) step();
`endif

      // Asynchronous reset in the middle of stWait
      Enable_i = 1'b1;
      waitQuery(40, waited);
      checkVal("preResetLat", waited, 4);
      step();
      Reset_n_i = 1'b0;
      Enable_i  = 1'b0;
      #1;
      for (int k = 0; k < NCH; k++) expWords[k] = '0;
      checkVal("resetValues", SensorValues_o, 0);
      checkVal("resetIntr", CpuIntr_o, 0);
      checkVal("resetQuery", Query, 0);
      checkVal("resetErrFlag", ErrorFlag_o, 0);
      checkVal("resetErrCh", ErrorChannel_o, 0);
      checkVal("resetChannel", Channel, 0);
      step();
      Reset_n_i = 1'b1;
      Done = 1'b1; Byte0 = 8'h77; Byte1 = 8'h77;
      q0 = queryCount;
      step();
      Done = 1'b0;
      repeat (10) step();
      checkVal("doneAfterReset", SensorValues_o, 0);
      checkVal("noQueryAfterReset", queryCount, q0);

      repeat (3) step();
      checkVal("intrQueueDrained", expIntrQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
